ysyx_csr_file: RTL and testbench

//  M-mode CSR file for the EXU: Zicsr RW/RS/RC access, trap entry, mret, trap-target generation.

---
 rtl/ysyx_csr_file_if.sv | 32 +++
 rtl/ysyx_csr_file.sv | 162 ++++++++++++++++
 tb/tb_ysyx_csr_file.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_csr_file_if.sv
// rtl/ysyx_csr_file_if.sv - EXU/IFU-facing signal bundle of the M-mode CSR file
interface ysyx_csr_file_if #(
    parameter int XLEN = 32
);
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret_valid;
    logic            retire;
    logic [XLEN-1:0] trap_target_o;
    logic [XLEN-1:0] mepc_o;
    logic            mie_o;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata,
        output trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, retire,
        input  csr_rdata, csr_illegal, trap_target_o, mepc_o, mie_o
    );

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata,
        input  trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, retire,
        output csr_rdata, csr_illegal, trap_target_o, mepc_o, mie_o
    );
endinterface

// File: rtl/ysyx_csr_file.sv
// rtl/ysyx_csr_file.sv - M-mode CSR file: Zicsr access, trap entry, mret, trap target
// Optional mcycle/minstret counters are enabled by defining YSYX_CSR_COUNTERS_EN.
module ysyx_csr_file #(
    parameter int              XLEN      = 32,
    parameter logic [31:0]     MVENDORID = 32'h79737978,
    parameter logic [31:0]     MARCHID   = 32'h015fde77,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input logic            clk,
    input logic            rst,
    ysyx_csr_file_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;
    localparam logic [1:0]  OP_RC = 2'b11;

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
    logic [XLEN-1:0] mstatus_rd, rdata, wval, trap_target;
    logic            known, read_only, writes, illegal, wr_en;

`ifdef YSYX_CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q, mcycle_d, minstret_d, ctr_sel;
`else
    wire unused_retire = bus.retire;
`endif

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    always_comb begin
        rdata     = '0;
        known     = 1'b1;
        read_only = 1'b0;
`ifdef YSYX_CSR_COUNTERS_EN
        ctr_sel   = bus.csr_addr[1] ? minstret_q : mcycle_q;
`endif
        case (bus.csr_addr)
            A_MSTATUS:   rdata = mstatus_rd;
            A_MTVEC:     rdata = mtvec_q;
            A_MSCRATCH:  rdata = mscratch_q;
            A_MEPC:      rdata = mepc_q;
            A_MCAUSE:    rdata = mcause_q;
            A_MTVAL:     rdata = mtval_q;
            A_MVENDORID: begin rdata = XLEN'(MVENDORID); read_only = 1'b1; end
            A_MARCHID:   begin rdata = XLEN'(MARCHID);   read_only = 1'b1; end
            A_MHARTID:   read_only = 1'b1;
            default: begin
                known = 1'b0;
`ifdef YSYX_CSR_COUNTERS_EN
                // Bxx/Cxx with offsets 00/02/80/82; high halves exist only on RV32.
                if ((bus.csr_addr[11:8] == 4'hB || bus.csr_addr[11:8] == 4'hC) &&
                    bus.csr_addr[6:2] == 5'd0 && !bus.csr_addr[0] &&
                    (!bus.csr_addr[7] || XLEN == 32)) begin
                    known     = 1'b1;
                    read_only = (bus.csr_addr[11:8] == 4'hC);
                    rdata     = bus.csr_addr[7] ? XLEN'(ctr_sel[63:32]) : ctr_sel[XLEN-1:0];
                end
`endif
            end
        endcase
    end

    // RS/RC with a zero operand is a pure read, even on read-only CSRs.
    assign writes  = (bus.csr_op == OP_RW) || (bus.csr_op != 2'b00 && bus.csr_wdata != '0);
    assign illegal = bus.csr_valid && bus.csr_op != 2'b00 && (!known || (read_only && writes));
    assign wr_en   = bus.csr_valid && writes && !illegal && !bus.trap_valid && !bus.mret_valid;

    always_comb begin
        case (bus.csr_op)
            OP_RW:   wval = bus.csr_wdata;
            OP_RS:   wval = rdata | bus.csr_wdata;
            OP_RC:   wval = rdata & ~bus.csr_wdata;
            default: wval = rdata;
        endcase
    end

    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && mcause_q[XLEN-1])
            trap_target = trap_target + {mcause_q[XLEN-3:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RST[XLEN-1:2], 1'b0, MTVEC_RST[0]};
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
        end else if (bus.trap_valid) begin
            mepc_q   <= bus.trap_pc & {{(XLEN-2){1'b1}}, 2'b00};
            mcause_q <= bus.trap_cause;
            mtval_q  <= bus.trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (bus.mret_valid) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en) begin
            case (bus.csr_addr)
                A_MSTATUS:  begin mie_q <= wval[3]; mpie_q <= wval[7]; end
                A_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], 1'b0, wval[0]};
                A_MSCRATCH: mscratch_q <= wval;
                A_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_q   <= wval;
                A_MTVAL:    mtval_q    <= wval;
                default: ;
            endcase
        end
    end

`ifdef YSYX_CSR_COUNTERS_EN
    // A write to either half replaces that counter's increment for the cycle.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.retire};
        if (wr_en && bus.csr_addr[11:8] == 4'hB) begin
            if (bus.csr_addr[1]) begin
                minstret_d = minstret_q;
                if (bus.csr_addr[7]) minstret_d[63:32]     = wval[31:0];
                else                 minstret_d[XLEN-1:0]  = wval;
            end else begin
                mcycle_d = mcycle_q;
                if (bus.csr_addr[7]) mcycle_d[63:32]       = wval[31:0];
                else                 mcycle_d[XLEN-1:0]    = wval;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    assign bus.csr_rdata     = rdata;
    assign bus.csr_illegal   = illegal;
    assign bus.trap_target_o = trap_target;
    assign bus.mepc_o        = mepc_q;
    assign bus.mie_o         = mie_q;
endmodule

// File: tb/tb_ysyx_csr_file.sv
// tb/tb_ysyx_csr_file.sv - directed bench for ysyx_csr_file with a CSR-level reference model
module tb_ysyx_csr_file;
    localparam int          XLEN      = 32;
    localparam logic [31:0] MVENDORID = 32'h79737978;
    localparam logic [31:0] MARCHID   = 32'h015fde77;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_csr_file_if #(.XLEN(XLEN)) bus ();
    ysyx_csr_file #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
`ifdef YSYX_CSR_COUNTERS_EN
    logic [63:0] m_cycle, m_instret;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
`ifdef YSYX_CSR_COUNTERS_EN
        m_cycle = 0; m_instret = 0;
`endif
    endtask

    task automatic model_read(input logic [11:0] a, output logic kn, output logic ro, output logic [31:0] v);
        kn = 1; ro = 0; v = 0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'hF11: begin v = MVENDORID; ro = 1; end
            12'hF12: begin v = MARCHID; ro = 1; end
            12'hF14: ro = 1;
`ifdef YSYX_CSR_COUNTERS_EN
            12'hB00: v = m_cycle[31:0];
            12'hB80: v = m_cycle[63:32];
            12'hB02: v = m_instret[31:0];
            12'hB82: v = m_instret[63:32];
            12'hC00: begin v = m_cycle[31:0];    ro = 1; end
            12'hC80: begin v = m_cycle[63:32];   ro = 1; end
            12'hC02: begin v = m_instret[31:0];  ro = 1; end
            12'hC82: begin v = m_instret[63:32]; ro = 1; end
`endif
            default: kn = 0;
        endcase
    endtask

    function automatic logic is_write();
        return bus.csr_op == 2'b01 || (bus.csr_op != 2'b00 && bus.csr_wdata != 0);
    endfunction

    function automatic logic exp_illegal(input logic kn, input logic ro);
        return bus.csr_valid && bus.csr_op != 2'b00 && (!kn || (ro && is_write()));
    endfunction

    task automatic compare();
        logic kn, ro;
        logic [31:0] v, tgt;
        model_read(bus.csr_addr, kn, ro, v);
        tgt = m_mtvec & ~32'd3;
        if (m_mtvec[0] && m_mcause[31]) tgt = tgt + (m_mcause << 2);
        chk("csr_rdata", bus.csr_rdata, v);
        chk("csr_illegal", 32'(bus.csr_illegal), 32'(exp_illegal(kn, ro)));
        chk("trap_target_o", bus.trap_target_o, tgt);
        chk("mepc_o", bus.mepc_o, m_mepc);
        chk("mie_o", 32'(bus.mie_o), 32'(m_mie));
    endtask

    task automatic model_step();
        logic kn, ro;
        logic [31:0] old, nv;
`ifdef YSYX_CSR_COUNTERS_EN
        logic [63:0] c0, i0;
`endif
        if (rst) begin
            model_reset();
            return;
        end
        model_read(bus.csr_addr, kn, ro, old);
`ifdef YSYX_CSR_COUNTERS_EN
        c0 = m_cycle; i0 = m_instret;
        m_cycle = m_cycle + 1;
        if (bus.retire) m_instret = m_instret + 1;
`endif
        if (bus.trap_valid) begin
            m_mepc = bus.trap_pc & ~32'd3;
            m_mcause = bus.trap_cause;
            m_mtval = bus.trap_tval;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (bus.mret_valid) begin
            m_mie = m_mpie;
            m_mpie = 1;
        end else if (bus.csr_valid && is_write() && !exp_illegal(kn, ro)) begin
            case (bus.csr_op)
                2'b01:   nv = bus.csr_wdata;
                2'b10:   nv = old | bus.csr_wdata;
                default: nv = old & ~bus.csr_wdata;
            endcase
            case (bus.csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv & ~32'd2;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
`ifdef YSYX_CSR_COUNTERS_EN
                12'hB00: m_cycle = {c0[63:32], nv};
                12'hB80: m_cycle = {nv, c0[31:0]};
                12'hB02: m_instret = {i0[63:32], nv};
                12'hB82: m_instret = {nv, i0[31:0]};
`endif
                default: ;
            endcase
        end
    endtask

    task automatic idle();
        bus.csr_valid = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
        bus.trap_valid = 0; bus.trap_cause = 0; bus.trap_pc = 0; bus.trap_tval = 0;
        bus.mret_valid = 0; bus.retire = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        idle();
        bus.csr_valid = 1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
    endtask

    task automatic trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        bus.trap_valid = 1; bus.trap_cause = cause; bus.trap_pc = pc; bus.trap_tval = tval;
    endtask

    task automatic sample();
        #2;
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;

        idle(); sample();
        chk("reset_mepc", bus.mepc_o, 32'h0);
        chk("reset_mie", 32'(bus.mie_o), 32'h0);
        chk("reset_target", bus.trap_target_o, 32'h0);
        advance();

        csr(2'b10, 12'h300, 32'h8); sample();
        chk("rs_mstatus_old", bus.csr_rdata, 32'h1800);
        advance();
        csr(2'b10, 12'h300, 32'h0); sample();
        chk("rs_mstatus_new", bus.csr_rdata, 32'h1808);
        chk("rs_mstatus_mie", 32'(bus.mie_o), 32'h1);
        advance();

        csr(2'b01, 12'h305, 32'h8000_0001); sample(); advance();
        idle(); trap(32'h8000_0007, 32'h8000_0102, 32'h55); sample(); advance();
        csr(2'b10, 12'h300, 32'h0); sample();
        chk("vec_irq_target", bus.trap_target_o, 32'h8000_001C);
        chk("trap_mepc", bus.mepc_o, 32'h8000_0100);
        chk("trap_mstatus", bus.csr_rdata, 32'h1880);
        advance();
        idle(); bus.mret_valid = 1; sample(); advance();
        csr(2'b10, 12'h300, 32'h0); sample();
        chk("mret_mstatus", bus.csr_rdata, 32'h1888);
        advance();

        csr(2'b01, 12'h341, 32'h1234); trap(32'h3, 32'h0000_0208, 32'h0); sample(); advance();
        idle(); sample();
        chk("trap_beats_write", bus.mepc_o, 32'h208);
        chk("vec_exc_target", bus.trap_target_o, 32'h8000_0000);
        advance();
        csr(2'b01, 12'h340, 32'hABCD); bus.mret_valid = 1; sample(); advance();
        csr(2'b10, 12'h340, 32'h0); sample();
        chk("mret_beats_write", bus.csr_rdata, 32'h0);
        advance();

        csr(2'b01, 12'hF12, 32'h1); sample();
        chk("rw_marchid_illegal", 32'(bus.csr_illegal), 32'h1);
        advance();
        csr(2'b10, 12'hF12, 32'h0); sample();
        chk("rs0_marchid_legal", 32'(bus.csr_illegal), 32'h0);
        chk("rs0_marchid_rdata", bus.csr_rdata, MARCHID);
        advance();
        csr(2'b11, 12'hF11, 32'h5); sample(); advance();
        csr(2'b10, 12'hF14, 32'h0); sample(); advance();
        csr(2'b10, 12'h7C0, 32'h0); sample();
        chk("unknown_illegal", 32'(bus.csr_illegal), 32'h1);
        advance();

        csr(2'b01, 12'h341, 32'h1237); sample(); advance();
        csr(2'b10, 12'h341, 32'h0); sample();
        chk("mepc_align", bus.csr_rdata, 32'h1234);
        advance();
        csr(2'b11, 12'h300, 32'hFFFF_FFFF); sample(); advance();
        csr(2'b10, 12'h300, 32'hFFFF_FFFF); sample();
        chk("mstatus_cleared", bus.csr_rdata, 32'h1800);
        advance();
        csr(2'b01, 12'h342, 32'h8000_0005); sample(); advance();
        csr(2'b01, 12'h343, 32'hDEAD_BEEF); sample(); advance();
        csr(2'b01, 12'h305, 32'hFFFF_FF03); sample(); advance();
        idle(); trap(32'hFFFF_FFFF, 32'h4, 32'h0); sample(); advance();
        idle(); sample();
        chk("vec_wrap_target", bus.trap_target_o, 32'hFFFF_FEFC);
        advance();
        csr(2'b01, 12'h305, 32'h0000_0400); trap(32'h8000_0003, 32'h0, 32'h0); sample(); advance();
        csr(2'b01, 12'h305, 32'h0000_0400); sample(); advance();
        idle(); sample();
        chk("direct_target", bus.trap_target_o, 32'h400);
        advance();

        rst = 1; csr(2'b01, 12'h340, 32'h77); trap(32'h2, 32'h100, 32'h1); bus.retire = 1;
        sample(); advance();
        rst = 0; idle(); sample();
        chk("rst_wins_mepc", bus.mepc_o, 32'h0);
        chk("rst_wins_target", bus.trap_target_o, 32'h0);
        advance();

`ifdef YSYX_CSR_COUNTERS_EN
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF); sample(); advance();
        csr(2'b01, 12'hB80, 32'hFFFF_FFFF); sample(); advance();
        idle(); sample(); advance();
        csr(2'b10, 12'hB00, 32'h0); sample();
        chk("mcycle_wrap", bus.csr_rdata, 32'h0);
        advance();
        for (int i = 0; i < 3; i++) begin
            idle(); bus.retire = 1; sample(); advance();
        end
        csr(2'b10, 12'hB02, 32'h0); sample();
        chk("minstret_3", bus.csr_rdata, 32'h3);
        advance();
        csr(2'b10, 12'hC02, 32'h0); sample(); advance();
        csr(2'b01, 12'hC00, 32'h1); sample();
        chk("cycle_ro_illegal", 32'(bus.csr_illegal), 32'h1);
        advance();
`else
        idle(); bus.retire = 1; sample(); advance();
        csr(2'b10, 12'hB00, 32'h0); sample();
        chk("ctr_absent_illegal", 32'(bus.csr_illegal), 32'h1);
        chk("ctr_absent_rdata", bus.csr_rdata, 32'h0);
        advance();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
